// File: rtl/soc_fpga_temperature_monitor_if.sv
// ---------------------------------------------------------------------------
// soc_fpga_temperature_monitor_if
//   Bundles the signals between the temperature sensor and the monitor,
//   together with the statistics and alarm flags the monitor produces.
//
//   Sensor side (driven by the sensor model / bench):
//     temperature [7:0]  raw sensor reading, stable while valid is high
//     valid              sensor data valid, asynchronous level
//     error              sensor error, asynchronous level
//   Monitor side (driven by the monitor):
//     avg_temp    [7:0]  current windowed average
//     avg_valid          one-cycle pulse when avg_temp is updated
//     max_temp    [7:0]  highest good sample since reset/clear
//     min_temp    [7:0]  lowest good sample since reset/clear
//     hot/cold/fault     alarm state flags
//
//   Modports: master = sensor/consumer side, slave = monitor side.
// ---------------------------------------------------------------------------
interface soc_fpga_temperature_monitor_if;
  logic [7:0] temperature;
  logic       valid;
  logic       error;
  logic [7:0] avg_temp;
  logic       avg_valid;
  logic [7:0] max_temp;
  logic [7:0] min_temp;
  logic       hot;
  logic       cold;
  logic       fault;

  modport master (
    output temperature, valid, error,
    input  avg_temp, avg_valid, max_temp, min_temp, hot, cold, fault
  );

  modport slave (
    input  temperature, valid, error,
    output avg_temp, avg_valid, max_temp, min_temp, hot, cold, fault
  );
endinterface

// File: rtl/soc_fpga_temperature_monitor.sv
// ---------------------------------------------------------------------------
// soc_fpga_temperature_monitor
//   Synchronises an asynchronous temperature sensor into the fabric clock,
//   captures one sample per VALID rising edge, keeps a power-of-two moving
//   average plus min/max, and runs a hysteretic NORMAL/HOT/COLD/FAULT alarm.
//
//   Ports:
//     i_clk    fabric clock, all state changes on rising edge
//     i_rst_n  asynchronous active-low reset
//     i_clear  synchronous clear of FAULT, statistics and averaging state
//     bus      sensor inputs and monitor outputs (slave modport)
//
//   Pipeline (VALID rise before edge k):
//     edges k, k+1 : 2-flop synchroniser
//     edge  k+2    : acceptance, sample and synchronised ERROR latched
//     edge  k+3    : average, min/max, AVG_VALID, error counter, FSM update
// ---------------------------------------------------------------------------
module soc_fpga_temperature_monitor #(
  parameter int AVG_LOG2       = 2,
  parameter int HOT_THRESHOLD  = 85,
  parameter int COLD_THRESHOLD = 10,
  parameter int HYSTERESIS     = 5,
  parameter int ERROR_LIMIT    = 3
) (
  input  logic                          i_clk,
  input  logic                          i_rst_n,
  input  logic                          i_clear,
  soc_fpga_temperature_monitor_if.slave bus
);

  localparam int DEPTH = 1 << AVG_LOG2;
  localparam int PTR_W = (AVG_LOG2 == 0) ? 1 : AVG_LOG2;
  localparam int SUM_W = 8 + AVG_LOG2;

  localparam logic [7:0] HOT_ON   = 8'(HOT_THRESHOLD);
  localparam logic [7:0] HOT_OFF  = 8'(HOT_THRESHOLD - HYSTERESIS);
  localparam logic [7:0] COLD_ON  = 8'(COLD_THRESHOLD);
  localparam logic [7:0] COLD_OFF = 8'(COLD_THRESHOLD + HYSTERESIS);
  localparam logic [3:0] ERR_LIM  = 4'(ERROR_LIMIT);

  // Parameter legality, checked at elaboration
  if (AVG_LOG2 < 0 || AVG_LOG2 > 3) begin : g_bad_avg_log2
    $fatal(1, "AVG_LOG2 must be 0..3");
  end
  if (ERROR_LIMIT < 1 || ERROR_LIMIT > 15) begin : g_bad_error_limit
    $fatal(1, "ERROR_LIMIT must be 1..15");
  end
  if (HOT_THRESHOLD - HYSTERESIS <= COLD_THRESHOLD + HYSTERESIS) begin : g_bad_thresholds
    $fatal(1, "HOT_THRESHOLD-HYSTERESIS must exceed COLD_THRESHOLD+HYSTERESIS");
  end

  typedef enum logic [1:0] {ST_NORMAL, ST_HOT, ST_COLD, ST_FAULT} state_t;

  // Synchronisers and acceptance edge detect
  logic [1:0] r_valid_sync;
  logic [1:0] r_err_sync;
  logic       r_valid_prev;
  logic       w_accept;

  // Captured sample awaiting processing
  logic       r_pend;
  logic       r_pend_err;
  logic [7:0] r_pend_temp;

  // Averaging and statistics
  logic [7:0]       r_buf [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] w_wr_ptr_next;
  logic [SUM_W-1:0] r_sum;
  logic [SUM_W-1:0] w_sum_next;
  logic [SUM_W:0]   w_sum_wide;
  logic [7:0]       w_oldest;
  logic [7:0]       w_avg_next;
  logic             r_prefill;
  logic [7:0]       r_avg;
  logic             r_avg_valid;
  logic [7:0]       r_max;
  logic [7:0]       r_min;
  logic [3:0]       r_err_cnt;
  logic [3:0]       w_err_cnt_next;
  logic             w_good_upd;
  logic             w_err_upd;

  state_t r_state;
  state_t w_state_next;

  assign w_accept = r_valid_sync[1] & ~r_valid_prev;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_valid_sync <= '0;
      r_err_sync   <= '0;
      r_valid_prev <= 1'b0;
      r_pend       <= 1'b0;
      r_pend_err   <= 1'b0;
      r_pend_temp  <= '0;
    end else begin
      r_valid_sync <= {r_valid_sync[0], bus.valid};
      r_err_sync   <= {r_err_sync[0], bus.error};
      r_valid_prev <= r_valid_sync[1];
      // A clear in the acceptance cycle drops the sample outright
      r_pend       <= w_accept & ~i_clear;
      if (w_accept) begin
        r_pend_temp <= bus.temperature;
        r_pend_err  <= r_err_sync[1];
      end
    end
  end

  // Clear also wins over a sample that is one cycle from being applied
  assign w_good_upd = r_pend & ~r_pend_err & ~i_clear;
  assign w_err_upd  = r_pend &  r_pend_err & ~i_clear;

  assign w_oldest      = r_buf[r_wr_ptr];
  assign w_wr_ptr_next = (AVG_LOG2 == 0) ? '0 : r_wr_ptr + 1'b1;
  // Sum always contains the oldest entry, so the subtraction cannot underflow
  assign w_sum_wide    = {1'b0, r_sum} + (SUM_W + 1)'(r_pend_temp) - (SUM_W + 1)'(w_oldest);
  assign w_sum_next    = r_prefill ? (SUM_W'(r_pend_temp) << AVG_LOG2) : w_sum_wide[SUM_W-1:0];
  assign w_avg_next    = 8'(w_sum_next >> AVG_LOG2);
  assign w_err_cnt_next = (r_err_cnt == ERR_LIM) ? r_err_cnt : r_err_cnt + 4'd1;

  // Ring buffer has no reset: the first good sample always prefills it
  always_ff @(posedge i_clk) begin
    if (w_good_upd) begin
      if (r_prefill) begin
        for (int i = 0; i < DEPTH; i++) r_buf[i] <= r_pend_temp;
      end else begin
        r_buf[r_wr_ptr] <= r_pend_temp;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sum       <= '0;
      r_wr_ptr    <= '0;
      r_prefill   <= 1'b1;
      r_avg       <= '0;
      r_avg_valid <= 1'b0;
      r_max       <= 8'd0;
      r_min       <= 8'd255;
      r_err_cnt   <= '0;
    end else begin
      r_avg_valid <= w_good_upd;
      if (i_clear) begin
        // Average output is deliberately held; prefill rebuilds the window
        r_wr_ptr  <= '0;
        r_prefill <= 1'b1;
        r_max     <= 8'd0;
        r_min     <= 8'd255;
        r_err_cnt <= '0;
      end else if (w_good_upd) begin
        r_sum     <= w_sum_next;
        r_avg     <= w_avg_next;
        r_wr_ptr  <= w_wr_ptr_next;
        r_prefill <= 1'b0;
        r_err_cnt <= '0;
        if (r_pend_temp > r_max) r_max <= r_pend_temp;
        if (r_pend_temp < r_min) r_min <= r_pend_temp;
      end else if (w_err_upd) begin
        r_err_cnt <= w_err_cnt_next;
      end
    end
  end

  // FSM: state register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)     r_state <= ST_NORMAL;
    else if (i_clear) r_state <= ST_NORMAL;
    else              r_state <= w_state_next;
  end

  // FSM: next state. FAULT is sticky; reaching the error limit beats everything.
  always_comb begin
    w_state_next = r_state;
    if (r_state != ST_FAULT) begin
      if (w_err_upd && (w_err_cnt_next == ERR_LIM)) begin
        w_state_next = ST_FAULT;
      end else if (w_good_upd) begin
        case (r_state)
          ST_NORMAL: begin
            if (w_avg_next >= HOT_ON)       w_state_next = ST_HOT;
            else if (w_avg_next <= COLD_ON) w_state_next = ST_COLD;
          end
          ST_HOT: begin
            if (w_avg_next <= COLD_ON)      w_state_next = ST_COLD;
            else if (w_avg_next < HOT_OFF)  w_state_next = ST_NORMAL;
          end
          ST_COLD: begin
            if (w_avg_next >= HOT_ON)       w_state_next = ST_HOT;
            else if (w_avg_next > COLD_OFF) w_state_next = ST_NORMAL;
          end
          default: w_state_next = r_state;
        endcase
      end
    end
  end

  // FSM: outputs
  always_comb begin
    bus.hot   = (r_state == ST_HOT);
    bus.cold  = (r_state == ST_COLD);
    bus.fault = (r_state == ST_FAULT);
  end

  assign bus.avg_temp  = r_avg;
  assign bus.avg_valid = r_avg_valid;
  assign bus.max_temp  = r_max;
  assign bus.min_temp  = r_min;

endmodule

// File: tb/tb_soc_fpga_temperature_monitor.sv
// ---------------------------------------------------------------------------
// tb_soc_fpga_temperature_monitor
//   Directed vectors with hand-computed expected averages, statistics and
//   alarm flags for the default parameter set (window of 4 samples,
//   HOT 85/80, COLD 10/15, error limit 3).
// ---------------------------------------------------------------------------
module tb_soc_fpga_temperature_monitor;

  logic clk = 1'b0;
  logic rst_n;
  logic clear;

  int n_vec  = 0;
  int n_miss = 0;

  soc_fpga_temperature_monitor_if bus_if ();

  soc_fpga_temperature_monitor dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_clear (clear),
    .bus     (bus_if.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_miss++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Starts on a negedge. VALID rises before edge k; AVG_VALID must be low
  // after edge k+2, high after edge k+3 for a good sample, low after k+4.
  task automatic send(input int temp, input bit err, input bit clr_at_accept,
                      input bit exp_pulse);
    bus_if.temperature = 8'(temp);
    bus_if.error       = err;
    bus_if.valid       = 1'b1;
    @(negedge clk);
    @(negedge clk);
    if (clr_at_accept) clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    check($sformatf("avg_valid_early t=%0d", temp), int'(bus_if.avg_valid), 0);
    @(negedge clk);
    check($sformatf("avg_valid t=%0d", temp), int'(bus_if.avg_valid), int'(exp_pulse));
    bus_if.valid = 1'b0;
    bus_if.error = 1'b0;
    @(negedge clk);
    check($sformatf("avg_valid_late t=%0d", temp), int'(bus_if.avg_valid), 0);
    repeat (3) @(negedge clk);
    $display("sample temp=%0d err=%0d clr=%0d -> avg=%0d max=%0d min=%0d hot=%0d cold=%0d fault=%0d",
             temp, err, clr_at_accept, bus_if.avg_temp, bus_if.max_temp, bus_if.min_temp,
             bus_if.hot, bus_if.cold, bus_if.fault);
  endtask

  task automatic good(input int temp, input int exp_avg, input bit exp_hot,
                      input bit exp_cold, input bit exp_fault);
    send(temp, 1'b0, 1'b0, 1'b1);
    check($sformatf("avg t=%0d", temp), int'(bus_if.avg_temp), exp_avg);
    check($sformatf("hot t=%0d", temp), int'(bus_if.hot), int'(exp_hot));
    check($sformatf("cold t=%0d", temp), int'(bus_if.cold), int'(exp_cold));
    check($sformatf("fault t=%0d", temp), int'(bus_if.fault), int'(exp_fault));
  endtask

  task automatic bad(input int exp_avg, input bit exp_fault);
    send(99, 1'b1, 1'b0, 1'b0);
    check("err_avg", int'(bus_if.avg_temp), exp_avg);
    check("err_fault", int'(bus_if.fault), int'(exp_fault));
  endtask

  task automatic do_clear();
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    @(negedge clk);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_avg"}, int'(bus_if.avg_temp), 0);
    check({tag, "_avg_valid"}, int'(bus_if.avg_valid), 0);
    check({tag, "_max"}, int'(bus_if.max_temp), 0);
    check({tag, "_min"}, int'(bus_if.min_temp), 255);
    check({tag, "_hot"}, int'(bus_if.hot), 0);
    check({tag, "_cold"}, int'(bus_if.cold), 0);
    check({tag, "_fault"}, int'(bus_if.fault), 0);
  endtask

  initial begin
    rst_n              = 1'b0;
    clear              = 1'b0;
    bus_if.temperature = 8'd0;
    bus_if.valid       = 1'b0;
    bus_if.error       = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_values("rst");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Reset group: five samples of 50
    for (int i = 0; i < 5; i++) good(50, 50, 1'b0, 1'b0, 1'b0);
    check("max50", int'(bus_if.max_temp), 50);
    check("min50", int'(bus_if.min_temp), 50);

    // Averaging and ring wrap
    do_clear();
    for (int i = 0; i < 4; i++) good(40, 40, 1'b0, 1'b0, 1'b0);
    good(80, 50, 1'b0, 1'b0, 1'b0);
    good(80, 60, 1'b0, 1'b0, 1'b0);
    good(80, 70, 1'b0, 1'b0, 1'b0);
    good(80, 80, 1'b0, 1'b0, 1'b0);
    good(80, 80, 1'b0, 1'b0, 1'b0);
    check("max80", int'(bus_if.max_temp), 80);
    check("min40", int'(bus_if.min_temp), 40);

    // HOT hysteresis: averages 84,85,82,80,79
    do_clear();
    good(84, 84, 1'b0, 1'b0, 1'b0);
    good(88, 85, 1'b1, 1'b0, 1'b0);
    good(72, 82, 1'b1, 1'b0, 1'b0);
    good(76, 80, 1'b1, 1'b0, 1'b0);
    good(80, 79, 1'b0, 1'b0, 1'b0);

    // COLD hysteresis: averages 11,10,14,15,16
    do_clear();
    good(11, 11, 1'b0, 1'b0, 1'b0);
    good(7,  10, 1'b0, 1'b1, 1'b0);
    good(27, 14, 1'b0, 1'b1, 1'b0);
    good(15, 15, 1'b0, 1'b1, 1'b0);
    good(15, 16, 1'b0, 1'b0, 1'b0);

    // Fault from HOT, sticky through a good sample, then cleared
    do_clear();
    good(90, 90, 1'b1, 1'b0, 1'b0);
    bad(90, 1'b0);
    bad(90, 1'b0);
    bad(90, 1'b1);
    check("fault_hot", int'(bus_if.hot), 0);
    check("fault_cold", int'(bus_if.cold), 0);
    good(90, 90, 1'b0, 1'b0, 1'b1);
    do_clear();
    check("clr_fault", int'(bus_if.fault), 0);
    check("clr_max", int'(bus_if.max_temp), 0);
    check("clr_min", int'(bus_if.min_temp), 255);

    // Error interleave: 1,1,0,1,1 never reaches the limit
    good(60, 60, 1'b0, 1'b0, 1'b0);
    bad(60, 1'b0);
    bad(60, 1'b0);
    good(60, 60, 1'b0, 1'b0, 1'b0);
    bad(60, 1'b0);
    bad(60, 1'b0);

    // CLEAR in the acceptance cycle drops the sample
    send(20, 1'b0, 1'b1, 1'b0);
    check("coll_avg", int'(bus_if.avg_temp), 60);
    check("coll_max", int'(bus_if.max_temp), 0);
    check("coll_min", int'(bus_if.min_temp), 255);

    // Reset while a sample is in the synchroniser
    bus_if.temperature = 8'd33;
    bus_if.valid       = 1'b1;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_reset_values("rst_mid");
    bus_if.valid = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    check_reset_values("rst_after");
    good(25, 25, 1'b0, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/soc_fpga_temperature_monitor.md
# soc_fpga_temperature_monitor

Downstream consumer of the SOC_FPGA_TEMPERATURE sensor model. It synchronises the sensor's TEMPERATURE/VALID/ERROR outputs into the fabric clock domain and captures one sample per VALID rising edge. It keeps a power-of-two moving average and min/max statistics. A hysteretic alarm state machine (NORMAL/HOT/COLD/FAULT) runs on the average and drives the flags the SoC thermal-management logic reads.

## Interface
- AVG_LOG2, 2: log2 of averaging window; legal 0..3 (1..8 samples).
- HOT_THRESHOLD, 85: enter HOT when average >= this (unsigned, °C).
- COLD_THRESHOLD, 10: enter COLD when average <= this.
- HYSTERESIS, 5: exit margin for HOT/COLD.
  - Legality: HOT_THRESHOLD-HYSTERESIS > COLD_THRESHOLD+HYSTERESIS.
  - An illegal value stops elaboration with $fatal.
- ERROR_LIMIT, 3: consecutive ERROR samples that force FAULT; legal 1..15.
- CLK  input  1  fabric clock; all state changes on its rising edge.
- RESET_N  input  1  asynchronous, active-low reset.
- TEMPERATURE  input  8  sensor data; asynchronous to CLK, stable while VALID high.
- VALID  input  1  sensor data valid; asynchronous level.
- ERROR  input  1  sensor error; asynchronous level.
- CLEAR  input  1  synchronous clear of FAULT, statistics and average.
- AVG_TEMP  output  8  current windowed average.
- AVG_VALID  output  1  one-cycle pulse when AVG_TEMP is updated.
- MAX_TEMP  output  8  highest good sample since reset or CLEAR.
- MIN_TEMP  output  8  lowest good sample since reset or CLEAR.
- HOT  output  1  state == HOT.
- COLD  output  1  state == COLD.
- FAULT  output  1  state == FAULT.

## Operation
- **Synchronisers.** VALID and ERROR each pass through a 2-flop synchroniser. TEMPERATURE is captured only on acceptance, never synchronised.
- **Acceptance.** A sample is accepted in cycle N, the first cycle the synchronised VALID is 1 after being 0.
- **Good sample:** synchronised ERROR = 0 at acceptance.
  - Writes the ring buffer and updates the running sum (width 8+AVG_LOG2).
  - Updates MAX/MIN and clears the error counter.
- **Prefill.** The first good sample after reset or CLEAR writes all 2^AVG_LOG2 entries. The sum becomes sample<<AVG_LOG2, so the first average equals that sample.
- **Steady state.** sum = sum + new - oldest entry. Write pointer wraps modulo 2^AVG_LOG2.
- **AVG_TEMP** = sum >> AVG_LOG2, truncated.
- **Error sample:** synchronised ERROR = 1 at acceptance.
  - Buffer, sum, AVG_TEMP and MAX/MIN are unchanged; no AVG_VALID.
  - Error counter increments and saturates at ERROR_LIMIT.
- **FSM.** States NORMAL, HOT, COLD, FAULT; evaluated on each new average.
  - NORMAL→HOT: avg >= HOT_THRESHOLD.
  - NORMAL→COLD: avg <= COLD_THRESHOLD.
  - HOT→NORMAL: avg < HOT_THRESHOLD-HYSTERESIS.
  - COLD→NORMAL: avg > COLD_THRESHOLD+HYSTERESIS.
  - HOT→COLD: avg <= COLD_THRESHOLD. COLD→HOT: avg >= HOT_THRESHOLD.
  - Any state→FAULT: error counter reaches ERROR_LIMIT. Highest priority; evaluated on each error sample.
  - FAULT is sticky. Only CLEAR or reset leaves it, to NORMAL; later good samples never exit FAULT.
- **CLEAR** (one cycle, synchronous) returns the block to its reset state:
  - FSM to NORMAL, error counter 0, MAX 0, MIN 255, prefill re-armed.
  - AVG_TEMP is held until the next good sample.
  - CLEAR in the acceptance cycle wins; that sample is dropped.
- **VALID held high:** yields exactly one sample; a new sample needs VALID low for at least 2 CLK cycles.

## Timing
- **Reset values:** AVG_TEMP 0, AVG_VALID 0, MAX_TEMP 0, MIN_TEMP 255, HOT/COLD/FAULT 0.
  - FSM NORMAL, error counter 0, prefill armed, synchronisers 0.
  - Reset applies immediately on RESET_N fall and releases on the first CLK after RESET_N rises.
- **Input latency:** a VALID rise before CLK edge k is accepted in cycle k+2 (edge k+2); the sample is latched at that edge.
- **Output latency:** AVG_TEMP, MAX/MIN and AVG_VALID update at edge k+3. HOT/COLD/FAULT update at edge k+3, from the new average or new error count.
- **Back-to-back:** one sample per 4 CLK cycles minimum (2 high + 2 low synchronised); no buffering beyond that.
- **Reset mid-sample:** a sample in flight is discarded with no partial update.

## Test plan
- **Reset:** reset, then 5 good samples of 50 -> AVG_TEMP=50 after each, AVG_VALID pulses once per sample 3 cycles after VALID rise, MAX=MIN=50, all flags 0.
- **Averaging and wrap, AVG_LOG2=2:** samples 40,40,40,40,80 -> averages 40,40,40,40,50. Then 80,80,80,80 -> 60,70,80,80 (ring wrap correct).
- **Hysteresis, defaults:** averages 84,85,82,80,79 -> HOT 0,1,1,1,0. Averages 11,10,14,15,16 -> COLD 0,1,1,1,0.
- **Fault:** ERROR=1 on 3 consecutive samples -> FAULT=1 on the third, HOT/COLD 0. Good samples keep FAULT=1 and AVG_TEMP unchanged. CLEAR -> FAULT 0, MAX 0, MIN 255.
- **Error interleave:** pattern ERROR 1,1,0,1,1 -> no FAULT (counter reset by good sample). Error samples never alter AVG_TEMP.
- **Collisions:** CLEAR in acceptance cycle -> sample dropped, no AVG_VALID. RESET_N low mid-synchroniser -> no update, all outputs at reset values.
